// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode/funct fields for M-extension decode and
// the state encoding of the iterative multiplier.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_SIGN = 2'b10,
    MUL_DONE = 2'b11
  } mul_state_e;

  // rs1 is treated as signed for MULH and MULHSU
  function automatic logic mul_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU);
  endfunction

  // rs2 is treated as signed for MULH only
  function automatic logic mul_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH);
  endfunction

endpackage

// File: rtl/twos_abs.sv
// Two's-complement magnitude extractor: returns |x| and the sign when x is
// interpreted as signed; passes x through unchanged when unsigned.
module twos_abs
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] x,
  input  logic            is_signed,
  output logic [XLEN-1:0] mag,
  output logic            sign
);

  // The most negative value maps onto itself, which is its correct unsigned magnitude
  always_comb begin
    sign = is_signed & x[XLEN-1];
    if (sign) begin
      mag = ~x + XLEN'(1);
    end else begin
      mag = x;
    end
  end

endmodule

// File: rtl/mul_unit_seq.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one multiplier bit per cycle.
// Optional macro MUL_EARLY_TERM_EN: leave RUN once the remaining multiplier is zero.
module mul_unit_seq
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int PW    = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mul_state_e      state_r, state_s;
  logic [2:0]      f3_r, f3_s;
  logic [PW-1:0]   mcand_r, mcand_s;
  logic [XLEN-1:0] mult_r, mult_s;
  logic [PW-1:0]   acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic            neg_r, neg_s;
  logic [XLEN-1:0] result_r, result_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;

  logic [XLEN-1:0] mag_a_s, mag_b_s;
  logic            sa_s, sb_s;
  logic [PW-1:0]   sum_s;
  logic [PW-1:0]   prod_s;
  logic            last_s;

  twos_abs #(.XLEN(XLEN)) u_abs_a (
    .x         (op_a),
    .is_signed (mul_a_signed(funct3)),
    .mag       (mag_a_s),
    .sign      (sa_s)
  );

  twos_abs #(.XLEN(XLEN)) u_abs_b (
    .x         (op_b),
    .is_signed (mul_b_signed(funct3)),
    .mag       (mag_b_s),
    .sign      (sb_s)
  );

  assign sum_s = acc_r + mcand_r;

  // Next-state, datapath updates and next values of the registered outputs
  always_comb begin
    state_s  = state_r;
    f3_s     = f3_r;
    mcand_s  = mcand_r;
    mult_s   = mult_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    neg_s    = neg_r;
    result_s = result_r;
    prod_s   = '0;
    last_s   = 1'b0;

    case (state_r)
      MUL_IDLE, MUL_DONE: begin
        if (start) begin
          f3_s = funct3;
          if (funct3[2]) begin
            // divide encodings are not handled here: complete immediately with zero
            result_s = '0;
            state_s  = MUL_DONE;
          end else begin
            mcand_s = {{XLEN{1'b0}}, mag_a_s};
            mult_s  = mag_b_s;
            acc_s   = '0;
            cnt_s   = '0;
            neg_s   = sa_s ^ sb_s;
            state_s = MUL_RUN;
          end
        end else begin
          state_s = MUL_IDLE;
        end
      end

      MUL_RUN: begin
        if (mult_r[0]) begin
          acc_s = sum_s;
        end else begin
          acc_s = acc_r;
        end
        mcand_s = mcand_r << 1;
        mult_s  = mult_r >> 1;
        cnt_s   = cnt_r + CNT_W'(1);
`ifdef MUL_EARLY_TERM_EN
        last_s  = (cnt_r == CNT_LAST) || (mult_r[XLEN-1:1] == '0);
`else
        last_s  = (cnt_r == CNT_LAST);
`endif
        if (last_s) begin
          state_s = MUL_SIGN;
        end else begin
          state_s = MUL_RUN;
        end
      end

      MUL_SIGN: begin
        if (neg_r) begin
          prod_s = ~acc_r + PW'(1);
        end else begin
          prod_s = acc_r;
        end
        if (f3_r == F3_MUL) begin
          result_s = prod_s[XLEN-1:0];
        end else begin
          result_s = prod_s[PW-1:XLEN];
        end
        state_s = MUL_DONE;
      end

      default: begin
        state_s = MUL_IDLE;
      end
    endcase

    busy_s = (state_s == MUL_RUN) || (state_s == MUL_SIGN);
    done_s = (state_s == MUL_DONE);
  end

  // State, datapath and output registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= MUL_IDLE;
      f3_r     <= 3'b000;
      mcand_r  <= '0;
      mult_r   <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      neg_r    <= 1'b0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      f3_r     <= f3_s;
      mcand_r  <= mcand_s;
      mult_r   <= mult_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      neg_r    <= neg_s;
      result_r <= result_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Self-checking bench for mul_unit_seq: directed vectors, handshake corner cases,
// reset abort and randomized operations against an arithmetic reference model.
module tb_mul_unit_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  mul_unit_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-precision product from sign/zero extended operands
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    if (f3[2]) return 32'h0;
    ea = ((f3 == 3'b001 || f3 == 3'b010) && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
    eb = ((f3 == 3'b001) && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
    p  = ea * eb;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // Edges from the driving edge to the first cycle with done high
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] mb;
    int n;
    if (f3[2]) return 1;
    mb = ((f3 == 3'b001) && b[31]) ? (32'h0 - b) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
    return n + 2;
`else
    if (f3[2]) return 1;
    return 34;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom() >> $urandom_range(0, 31);
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive a request; caller is positioned just after a rising edge
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
  endtask

  // Count edges until done; optionally check busy each cycle and inject a start pulse at pulse_k
  task automatic wait_done(input string name, input int pulse_k, input bit chk_busy, input int exp_l,
                           output logic [31:0] res, output int lat);
    lat = 0;
    res = 32'h0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 3));
        op_a   = $urandom();
        op_b   = $urandom();
      end
      if (pulse_k != 0 && k == pulse_k) launch(3'b000, $urandom(), $urandom());
      if (pulse_k != 0 && k == pulse_k + 1) start = 1'b0;
      if (chk_busy) check($sformatf("%s_busy_k%0d", name, k), {63'h0, busy}, {63'h0, (k < exp_l) ? 1'b1 : 1'b0});
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  logic [31:0] r;
  int          l;
  int          el;
  int          dones;
  logic [2:0]  rf3;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = 32'h0;
    op_b   = 32'h0;

    vecs[0]  = '{3'b000, 32'h00000007, 32'h00000006, 32'h0000002A};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[4]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[5]  = '{3'b010, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    vecs[6]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[7]  = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[8]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[9]  = '{3'b000, 32'h00000009, 32'h00000000, 32'h00000000};
    vecs[10] = '{3'b000, 32'h00000009, 32'h00000005, 32'h0000002D};
    vecs[11] = '{3'b100, 32'h00000005, 32'h00000003, 32'h00000000};
    vecs[12] = '{3'b000, 32'h00000001, 32'h00000001, 32'h00000001};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy",   {63'h0, busy},   64'h0);
    check("reset_done",   {63'h0, done},   64'h0);
    check("reset_result", {32'h0, result}, 64'h0);

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      launch(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), 0, 1'b0, 0, r, l);
      check($sformatf("vec%0d_result", i), {32'h0, r}, {32'h0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), 64'(l), 64'(exp_lat(vecs[i].f3, vecs[i].b)));
    end

    // busy profile and single-cycle done pulse for MUL 7 x 6
    @(posedge clk); #1;
    el = exp_lat(3'b000, 32'd6);
    launch(3'b000, 32'd7, 32'd6);
    wait_done("prof", 0, 1'b1, el, r, l);
    check("prof_result", {32'h0, r}, 64'h2A);
    check("prof_latency", 64'(l), 64'(el));
    @(posedge clk); #1;
    check("prof_done_pulse", {63'h0, done}, 64'h0);

    // start pulses while busy are ignored and not queued
    @(posedge clk); #1;
    launch(3'b011, 32'h12345678, 32'h80000001);
    wait_done("midrun", 10, 1'b1, 34, r, l);
    check("midrun_result", {32'h0, r}, {32'h0, ref_res(3'b011, 32'h12345678, 32'h80000001)});
    check("midrun_latency", 64'(l), 64'd34);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("midrun_not_queued", 64'(dones), 64'h0);

    // back-to-back: a start during the done cycle is accepted
    @(posedge clk); #1;
    launch(3'b000, 32'd7, 32'd6);
    wait_done("b2b_first", 0, 1'b0, 0, r, l);
    check("b2b_first_result", {32'h0, r}, 64'h2A);
    launch(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("b2b_second", 0, 1'b0, 0, r, l);
    check("b2b_second_result", {32'h0, r}, 64'hFFFFFFFE);
    check("b2b_second_latency", 64'(l), 64'(exp_lat(3'b011, 32'hFFFFFFFF)));

    // reset ten cycles into an operation abandons it
    @(posedge clk); #1;
    launch(3'b000, 32'h00001234, 32'h8000FFFF);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("midrst_busy",   {63'h0, busy},   64'h0);
    check("midrst_done",   {63'h0, done},   64'h0);
    check("midrst_result", {32'h0, result}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("midrst_nothing_completes", 64'(dones), 64'h0);
    @(posedge clk); #1;
    launch(3'b000, 32'd3, 32'd5);
    wait_done("postrst", 0, 1'b0, 0, r, l);
    check("postrst_result", {32'h0, r}, 64'hF);
    check("postrst_latency", 64'(l), 64'(exp_lat(3'b000, 32'd5)));

    // randomized operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      rf3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      @(posedge clk); #1;
      launch(rf3, ra, rb);
      wait_done("rnd", 0, 1'b0, 0, r, l);
      check($sformatf("rnd%0d_f%0d_%h_%h_result", i, rf3, ra, rb), {32'h0, r}, {32'h0, ref_res(rf3, ra, rb)});
      check($sformatf("rnd%0d_latency", i), 64'(l), 64'(exp_lat(rf3, rb)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
